// File: rtl/classifier_pkg.sv
// Shared types and constants for the pixel-classifier configuration controller:
// threshold bank layout, register map, CTRL/STATUS bit positions and reset defaults.
package classifier_pkg;

    localparam int NUM_TH = 12;
    localparam int TH_W   = 9;
    localparam int CFG_W  = NUM_TH * TH_W;

    // Element k of a bank occupies bits [9k+8:9k] of the flattened bus.
    typedef logic [NUM_TH-1:0][TH_W-1:0] th_bank_t;

    localparam th_bank_t TH_DEFAULT = {
        9'd330, 9'd270, 9'd250, 9'd200, 9'd180, 9'd160,
        9'd70,  9'd50,  9'd330, 9'd30,  9'd50,  9'd70
    };

    localparam logic [4:0] ADDR_CTRL        = 5'd12;
    localparam logic [4:0] ADDR_STATUS      = 5'd13;
    localparam logic [4:0] ADDR_ACTIVE_BASE = 5'd16;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_ABORT_BIT  = 1;

    localparam int STAT_PENDING_BIT  = 0;
    localparam int STAT_IN_FRAME_BIT = 1;
    localparam int STAT_DRAINING_BIT = 2;
    localparam int STAT_FCNT_LSB     = 16;

    typedef enum logic [1:0] {
        CFG_IDLE,
        CFG_PENDING,
        CFG_APPLY
    } cfg_state_e;

endpackage

// File: rtl/classifier_cfg_ctrl_frame_tracker.sv
// Observes the classifier input stream: in-frame flag, post-EOP pipeline drain
// counter and a wrapping frame counter.
module frame_tracker #(
    parameter int PIPE_LAT = 2,
    parameter int FCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              in_frame,
    output logic              draining,
    output logic [FCNT_W-1:0] frame_count
);

    localparam int DW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

    logic [DW-1:0] drain_cnt;
    logic          eop_beat;
    logic          sop_beat;

    assign eop_beat = in_valid && in_eop;
    assign sop_beat = in_valid && in_sop;
    assign draining = (drain_cnt != '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_frame    <= 1'b0;
            drain_cnt   <= '0;
            frame_count <= '0;
        end else begin
            // EOP has priority so a single-beat frame leaves in_frame clear.
            if (eop_beat)
                in_frame <= 1'b0;
            else if (sop_beat)
                in_frame <= 1'b1;

            if (eop_beat)
                drain_cnt <= DW'(PIPE_LAT);
            else if (drain_cnt != '0)
                drain_cnt <= drain_cnt - 1'b1;

            if (eop_beat)
                frame_count <= frame_count + 1'b1;
        end
    end

endmodule

// File: rtl/classifier_cfg_ctrl.sv
// Shadow/active HSV threshold banks with a frame-safe deferred commit.
// Optional macro CLASSIFIER_CFG_READBACK_EN enables readback of both banks.
module classifier_cfg_ctrl
    import classifier_pkg::*;
#(
    parameter int PIPE_LAT = 2,
    parameter int FCNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       s_address,
    input  logic             s_write,
    input  logic [31:0]      s_writedata,
    input  logic             s_read,
    output logic [31:0]      s_readdata,
    output logic             s_readdatavalid,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic [CFG_W-1:0] classifier_config,
    output logic             cfg_applied,
    output logic             cfg_pending
);

    th_bank_t          shadow;
    th_bank_t          active;
    cfg_state_e        state;
    logic              in_frame;
    logic              draining;
    logic [FCNT_W-1:0] frame_count;
    logic              ctrl_wr;
    logic              commit;
    logic              abort;
    logic              quiet;
    logic [31:0]       status;
    logic [31:0]       rd_data;
    logic              unused_wdata;

    assign unused_wdata = ^s_writedata[31:TH_W];

    frame_tracker #(
        .PIPE_LAT (PIPE_LAT),
        .FCNT_W   (FCNT_W)
    ) u_frame_tracker (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_frame    (in_frame),
        .draining    (draining),
        .frame_count (frame_count)
    );

    assign ctrl_wr = s_write && (s_address == ADDR_CTRL);
    assign abort   = ctrl_wr && s_writedata[CTRL_ABORT_BIT];
    assign commit  = ctrl_wr && s_writedata[CTRL_COMMIT_BIT] && !s_writedata[CTRL_ABORT_BIT];
    // An EOP beat this cycle would start a drain the registered flags cannot show yet.
    assign quiet   = !in_frame && !draining && !(in_valid && in_eop);

    // NOTE: the threshold banks are plain registers, so they take their
    // defaults from reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            shadow <= TH_DEFAULT;
        else if (s_write && (s_address < 5'(NUM_TH)))
            shadow[s_address[3:0]] <= s_writedata[TH_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= CFG_IDLE;
            active      <= TH_DEFAULT;
            cfg_pending <= 1'b0;
            cfg_applied <= 1'b0;
        end else begin
            cfg_applied <= 1'b0;
            case (state)
                CFG_PENDING: begin
                    if (abort) begin
                        state       <= CFG_IDLE;
                        cfg_pending <= 1'b0;
                    end else if (quiet) begin
                        active      <= shadow;
                        state       <= CFG_APPLY;
                        cfg_applied <= 1'b1;
                        cfg_pending <= 1'b0;
                    end
                end
                default: begin
                    state <= CFG_IDLE;
                    if (commit) begin
                        state       <= CFG_PENDING;
                        cfg_pending <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign classifier_config = active;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        status = '0;
        status[STAT_PENDING_BIT]             = cfg_pending;
        status[STAT_IN_FRAME_BIT]            = in_frame;
        status[STAT_DRAINING_BIT]            = draining;
        status[STAT_FCNT_LSB +: FCNT_W]      = frame_count;
    end

    always_comb begin
        rd_data = '0;
        if (s_address == ADDR_STATUS)
            rd_data = status;
`ifdef CLASSIFIER_CFG_READBACK_EN
        else if (s_address < 5'(NUM_TH))
            rd_data = 32'(shadow[s_address[3:0]]);
        else if ((s_address >= ADDR_ACTIVE_BASE) && (s_address < ADDR_ACTIVE_BASE + 5'(NUM_TH)))
            rd_data = 32'(active[s_address[3:0]]);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_readdata      <= '0;
            s_readdatavalid <= 1'b0;
        end else begin
            s_readdatavalid <= s_read;
            s_readdata      <= s_read ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_classifier_cfg_ctrl.sv
// Self-checking bench for classifier_cfg_ctrl: register-map vector table plus
// directed commit/abort/drain sequences against a small bank model.
module tb_classifier_cfg_ctrl;

    localparam logic [107:0] DEF = {
        9'd330, 9'd270, 9'd250, 9'd200, 9'd180, 9'd160,
        9'd70,  9'd50,  9'd330, 9'd30,  9'd50,  9'd70
    };
`ifdef CLASSIFIER_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   s_address;
    logic         s_write;
    logic [31:0]  s_writedata;
    logic         s_read;
    logic [31:0]  s_readdata;
    logic         s_readdatavalid;
    logic         in_valid, in_sop, in_eop;
    logic [107:0] classifier_config;
    logic         cfg_applied;
    logic         cfg_pending;

    int n_total = 0;
    int n_pass  = 0;

    logic [107:0] m_shadow;
    logic [107:0] m_active;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rb;
    } vec_t;

    vec_t vecs [10];

    classifier_cfg_ctrl #(.PIPE_LAT(2), .FCNT_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_address         (s_address),
        .s_write           (s_write),
        .s_writedata       (s_writedata),
        .s_read            (s_read),
        .s_readdata        (s_readdata),
        .s_readdatavalid   (s_readdatavalid),
        .in_valid          (in_valid),
        .in_sop            (in_sop),
        .in_eop            (in_eop),
        .classifier_config (classifier_config),
        .cfg_applied       (cfg_applied),
        .cfg_pending       (cfg_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [107:0] act, input logic [107:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        s_address   = a;
        s_writedata = d;
        s_write     = 1'b1;
        tick();
        s_write = 1'b0;
        if (a < 5'd12)
            m_shadow[9*a +: 9] = d[8:0];
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        s_address = a;
        s_read    = 1'b1;
        tick();
        s_read = 1'b0;
        check("readdatavalid", 108'(s_readdatavalid), 108'(1));
        d = s_readdata;
    endtask

    task automatic beat(input logic sop, input logic eop);
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        tick();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic wait_applied(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (cfg_applied) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        logic [31:0] d;
        bit          seen;
        bit          bad;

        vecs[0] = '{5'd3,  32'hFFFF_FE05, 32'd5};
        vecs[1] = '{5'd11, 32'd400,       32'd400};
        vecs[2] = '{5'd20, 32'd77,        32'd50};
        vecs[3] = '{5'd12, 32'd2,         32'd0};
        vecs[4] = '{5'd13, 32'hFFFF_FFFF, 32'd0};
        vecs[5] = '{5'd31, 32'd5,         32'd0};
        vecs[6] = '{5'd14, 32'd1,         32'd0};
        vecs[7] = '{5'd3,  32'd330,       32'd330};
        vecs[8] = '{5'd11, 32'd330,       32'd330};
        vecs[9] = '{5'd27, 32'd0,         32'd330};

        rst = 1'b1;
        s_address = '0; s_write = 1'b0; s_writedata = '0; s_read = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        m_shadow = DEF;
        m_active = DEF;
        repeat (3) tick();

        check("reset config",   classifier_config, DEF);
        check("reset applied",  108'(cfg_applied), 108'(0));
        check("reset pending",  108'(cfg_pending), 108'(0));
        check("reset rdvalid",  108'(s_readdatavalid), 108'(0));
        check("reset rdata",    108'(s_readdata), 108'(0));
        rst = 1'b0;
        tick();
        rd(5'd13, d);
        check("status after reset", 108'(d), 108'(0));

        // Register map: write then read each address.
        for (int i = 0; i < 10; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, d);
            check($sformatf("vec%0d addr %0d", i, vecs[i].addr), 108'(d),
                  108'(RB ? vecs[i].exp_rb : 32'd0));
        end
        check("config untouched by map writes", classifier_config, m_active);

        // Readback of shadow vs active around an idle commit.
        wr(5'd9, 32'd240);
        rd(5'd9, d);
        check("shadow 9 readback", 108'(d), 108'(RB ? 32'd240 : 32'd0));
        rd(5'd25, d);
        check("active 9 before apply", 108'(d), 108'(RB ? 32'd250 : 32'd0));
        wr(5'd12, 32'd1);
        tick();
        check("rb commit applied", 108'(cfg_applied), 108'(1));
        m_active = m_shadow;
        rd(5'd25, d);
        check("active 9 after apply", 108'(d), 108'(RB ? 32'd240 : 32'd0));

        // Idle commit latency.
        wr(5'd2, 32'd45);
        check("config holds before commit", classifier_config, m_active);
        wr(5'd12, 32'd1);
        check("idle pending N+1", 108'(cfg_pending), 108'(1));
        check("idle applied N+1", 108'(cfg_applied), 108'(0));
        tick();
        check("idle applied N+2", 108'(cfg_applied), 108'(1));
        check("idle pending N+2", 108'(cfg_pending), 108'(0));
        check("idle red_hi", 108'(classifier_config[26:18]), 108'(45));
        m_active = m_shadow;
        check("idle config", classifier_config, m_active);
        tick();
        check("applied is a pulse", 108'(cfg_applied), 108'(0));

        // Commit during a frame waits for EOP plus drain.
        beat(1'b1, 1'b0);
        wr(5'd7, 32'd190);
        wr(5'd12, 32'd1);
        rd(5'd13, d);
        check("status pending+in_frame", 108'(d), 108'(32'h3));
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bad |= cfg_applied;
            tick();
        end
        check("no apply mid-frame", 108'(bad), 108'(0));
        beat(1'b0, 1'b1);
        check("config at eop", classifier_config, m_active);
        tick();
        tick();
        check("no apply while draining", 108'(cfg_applied), 108'(0));
        check("config during drain", classifier_config, m_active);
        check("pending during drain", 108'(cfg_pending), 108'(1));
        tick();
        check("apply at eop+3", 108'(cfg_applied), 108'(1));
        check("grn_hi applied", 108'(classifier_config[71:63]), 108'(190));
        m_active = m_shadow;
        check("frame config", classifier_config, m_active);
        rd(5'd13, d);
        check("status frame_count 1", 108'(d), 108'(32'h0001_0000));

        // Abort cancels a pending commit.
        wr(5'd5, 32'd99);
        beat(1'b1, 1'b0);
        wr(5'd12, 32'd1);
        check("abort: pending set", 108'(cfg_pending), 108'(1));
        wr(5'd12, 32'd2);
        check("abort: pending cleared", 108'(cfg_pending), 108'(0));
        beat(1'b0, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bad |= cfg_applied;
            tick();
        end
        check("abort: no apply", 108'(bad), 108'(0));
        check("abort: config unchanged", classifier_config, m_active);
        rd(5'd13, d);
        check("status frame_count 2", 108'(d), 108'(32'h0002_0000));

        // Shadow write while pending is included in the applied bank.
        beat(1'b1, 1'b0);
        wr(5'd12, 32'd1);
        wr(5'd0, 32'd100);
        beat(1'b0, 1'b1);
        wait_applied(10, seen);
        check("wp: apply seen", 108'(seen), 108'(1));
        check("wp: sat_min", 108'(classifier_config[8:0]), 108'(100));
        m_active = m_shadow;
        check("wp: config", classifier_config, m_active);

        // COMMIT and ABORT together: ABORT wins.
        tick();
        wr(5'd12, 32'd3);
        check("commit+abort pending", 108'(cfg_pending), 108'(0));
        tick();
        check("commit+abort applied", 108'(cfg_applied), 108'(0));

        // Single-beat frame: in_frame stays clear, drain starts.
        beat(1'b1, 1'b1);
        rd(5'd13, d);
        check("sop+eop status", 108'(d), 108'(32'h0004_0004));

        // Reset mid-frame drops pending commit and restores defaults.
        beat(1'b1, 1'b0);
        wr(5'd12, 32'd1);
        rst = 1'b1;
        #2;
        check("reset drops pending", 108'(cfg_pending), 108'(0));
        check("reset restores config", classifier_config, DEF);
        tick();
        rst = 1'b0;
        m_shadow = DEF;
        m_active = DEF;
        tick();
        rd(5'd13, d);
        check("status after mid-frame reset", 108'(d), 108'(0));
        wr(5'd12, 32'd1);
        wait_applied(4, seen);
        check("post-reset commit seen", 108'(seen), 108'(1));
        check("post-reset config", classifier_config, m_active);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/classifier_cfg_ctrl.md
# classifier_cfg_ctrl

Host-facing configuration controller for the pixel classifier. Holds a shadow bank of the twelve 9-bit HSV thresholds, written by a simple memory-mapped port, and an active bank that drives the classifier's 108-bit `classifier_config` bus. A host commit is deferred until the pixel stream is between frames and the HSV pipeline has drained, so every frame is classified with one consistent threshold set.

## Interface
- `PIPE_LAT`, 2: cycles from a pixel entering `PIXEL_PROC` until it is classified; sets the post-EOP drain time.
- `FCNT_W`, 16: frame counter width.
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_address` in 5: register address.
- `s_write` in 1: write strobe.
- `s_writedata` in 32: write data.
- `s_read` in 1: read strobe.
- `s_readdata` out 32: read data.
- `s_readdatavalid` out 1: one cycle after `s_read`.
- `in_valid` in 1: pixel beat valid on the classifier input stream (observe only).
- `in_sop` in 1: first pixel of frame, qualified by `in_valid`.
- `in_eop` in 1: last pixel of frame, qualified by `in_valid`.
- `classifier_config` out 108: active thresholds, index k at bits [9k+8:9k].
- `cfg_applied` out 1: one-cycle pulse, first cycle a new active bank is visible.
- `cfg_pending` out 1: commit requested, not yet applied.

## Operation
- Threshold indices and reset defaults:
  - 0 sat_min=70
  - 1 val_min=50
  - 2 red_hi=30
  - 3 red_lo=330
  - 4 yel_lo=50
  - 5 yel_hi=70
  - 6 grn_lo=160
  - 7 grn_hi=180
  - 8 blu_lo=200
  - 9 blu_hi=250
  - 10 pnk_lo=270
  - 11 pnk_hi=330
- Address map:
  - 0–11: shadow threshold k. A write stores `s_writedata[8:0]`; upper bits are ignored. Values ≥360 are stored unchanged.
  - 12 CTRL, write-only: bit0 COMMIT, bit1 ABORT. ABORT wins if both bits are set. Reads return 0.
  - 13 STATUS, read-only: bit0 pending, bit1 in_frame, bit2 draining, [16+FCNT_W-1:16] frame_count.
  - Unmapped addresses: writes are ignored, reads return 0.
- Frame tracking:
  - in_frame sets on `in_valid&in_sop` and clears on `in_valid&in_eop`. A single beat with both sop and eop leaves in_frame=0.
  - On `in_valid&in_eop`, the drain counter loads PIPE_LAT, then decrements to 0. draining = (counter≠0).
  - frame_count increments on `in_valid&in_eop` and wraps to 0.
- FSM:
  - IDLE: COMMIT → PENDING. ABORT is a no-op.
  - PENDING:
    - ABORT → IDLE; the active bank is unchanged.
    - COMMIT is a no-op.
    - When !in_frame and !draining, and no `in_valid&in_eop` in the same cycle → APPLY.
  - APPLY, one cycle: active ← shadow (the shadow contents at this edge, including writes made while pending) → IDLE.
  - An `in_sop` beat in the APPLY-enable cycle does not block the apply: that pixel reaches the classifier PIPE_LAT≥1 cycles later and sees the new bank.
- Simultaneous events:
  - A shadow write and an apply in the same cycle: the copy takes the pre-write shadow value, and the write lands in the shadow.
  - Writes to shadow never alter the active bank outside APPLY.

## Timing
- Reset values:
  - Shadow and active banks: defaults above.
  - All other state cleared: FSM=IDLE, pending=0, in_frame=0, drain=0, frame_count=0.
  - All outputs: `s_readdata`=0, `s_readdatavalid`=0, `cfg_applied`=0, `cfg_pending`=0.
- Reset mid-frame discards any pending commit. After reset deasserts, tracking assumes the stream is between frames.
- Reads: `s_readdata` and `s_readdatavalid` are registered, with latency 1. A read and a write to the same address in one cycle return the old value.
- COMMIT write at edge N: `cfg_pending`=1 from N+1. If idle, the apply occurs at edge N+1; `classifier_config` updates, `cfg_applied`=1 and `cfg_pending`=0 from N+2.
- EOP accepted at edge E: the earliest apply is edge E+PIPE_LAT+1.

## Configuration
- `CLASSIFIER_CFG_READBACK_EN` defined:
  - Addresses 0–11 read back the shadow bank.
  - Addresses 16–27 read the active threshold (k = addr−16).
- Not defined:
  - Threshold registers are write-only; reads of 0–11 and 16–27 return 0.
  - CTRL/STATUS behaviour is unchanged.

## Structure
- Package `classifier_pkg` holds:
  - NUM_TH=12, TH_W=9, CFG_W=108
  - register address constants
  - CTRL/STATUS bit positions
  - the default threshold array
- Sub-module `frame_tracker` (in_frame, drain counter, frame_count) feeds the commit FSM.

## Test plan
- Reset: `classifier_config` = default concatenation ({330,270,250,200,180,160,70,50,330,30,50,70}, MSB first); STATUS reads 0.
- Idle commit: write addr 2 = 45, then COMMIT → `cfg_applied` 2 cycles after the COMMIT write; `classifier_config[26:18]`=45.
- Mid-frame commit: sop beat, write addr 7 = 190, COMMIT; eop 20 cycles later → active unchanged until eop+PIPE_LAT+1, then [71:63]=190; frame_count=1.
- Abort: COMMIT mid-frame, then ABORT, then eop → no `cfg_applied`, active unchanged, pending=0.
- Write while pending: COMMIT mid-frame, then write addr 0 = 100 before eop → the applied bank has sat_min=100.
- Readback (macro on): write addr 9 = 240 → read addr 9 returns 240, read addr 25 returns 250 until apply, then 240. Macro off: both reads return 0.
